// File: rtl/ctrl_seq_pkg.sv
// Shared opcode and state encodings for the VeriRISC control sequencer family.
// The CTRL_SEQ_SINGLE_STEP_EN build option only affects ctrl_seq itself.
package ctrl_seq_pkg;

  typedef enum logic [2:0] {
    HLT = 3'd0,
    SKZ = 3'd1,
    ADD = 3'd2,
    AND = 3'd3,
    XOR = 3'd4,
    LDA = 3'd5,
    STO = 3'd6,
    JMP = 3'd7
  } opcode_t;

  typedef enum logic [3:0] {
    INST_ADDR  = 4'd0,
    INST_FETCH = 4'd1,
    INST_LOAD  = 4'd2,
    IDLE       = 4'd3,
    OP_ADDR    = 4'd4,
    OP_FETCH   = 4'd5,
    ALU_OP     = 4'd6,
    STORE      = 4'd7,
    HALTED     = 4'd8,
    STEP_HOLD  = 4'd9
  } ctrl_state_t;

  // Opcodes that read an operand from memory and load the accumulator
  function automatic logic is_aluop(input opcode_t op);
    case (op)
      ADD, AND, XOR, LDA: is_aluop = 1'b1;
      default:            is_aluop = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_wait_cnt.sv
// Memory wait-state counter: counts held cycles up to MEM_WAIT and raises done
// once the hold is satisfied; it saturates rather than wrapping.
module ctrl_wait_cnt #(
  parameter int MEM_WAIT = 0
) (
  input  logic clk,
  input  logic rst_,
  input  logic hold_req,
  input  logic clear,
  output logic done
);

  localparam int CNT_W = (MEM_WAIT > 0) ? $clog2(MEM_WAIT + 1) : 1;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MEM_WAIT);

  logic [CNT_W-1:0] cnt_r;

  // Held-cycle counter; cleared whenever the sequencer changes state
  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      cnt_r <= '0;
    end else if (clear) begin
      cnt_r <= '0;
    end else if (hold_req && (cnt_r != LIMIT)) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign done = (cnt_r == LIMIT);

endmodule

// File: rtl/ctrl_seq.sv
// VeriRISC control sequencer with memory wait states, sticky HALTED and debug state.
// Build option CTRL_SEQ_SINGLE_STEP_EN adds step_mode/step and the STEP_HOLD state.
module ctrl_seq
  import ctrl_seq_pkg::*;
#(
  parameter int MEM_WAIT = 0,
  parameter int OPCODE_W = 3
) (
  input  logic                clk,
  input  logic                rst_,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  input  logic                run,
  output logic                load_ac,
  output logic                mem_rd,
  output logic                mem_wr,
  output logic                inc_pc,
  output logic                load_pc,
  output logic                load_ir,
  output logic                halt,
  output logic                instr_done,
  output ctrl_state_t         state
`ifdef CTRL_SEQ_SINGLE_STEP_EN
  ,
  input  logic                step_mode,
  input  logic                step
`endif
);

  ctrl_state_t state_r;
  ctrl_state_t next_state_s;
  opcode_t     op_s;
  logic        aluop_s;
  logic        hold_req_s;
  logic        wait_clear_s;
  logic        wait_done_s;

  assign op_s    = opcode_t'(opcode);
  assign aluop_s = is_aluop(op_s);
  assign state   = state_r;

  // Only the instruction fetch and ALU-class operand fetch wait on memory
  assign hold_req_s   = (state_r == INST_FETCH) || ((state_r == OP_FETCH) && aluop_s);
  assign wait_clear_s = (next_state_s != state_r);

  ctrl_wait_cnt #(
    .MEM_WAIT (MEM_WAIT)
  ) u_wait_cnt (
    .clk      (clk),
    .rst_     (rst_),
    .hold_req (hold_req_s),
    .clear    (wait_clear_s),
    .done     (wait_done_s)
  );

  // State register
  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      state_r <= INST_ADDR;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode; unknown encodings recover to INST_ADDR
  always_comb begin
    next_state_s = INST_ADDR;
    case (state_r)
      INST_ADDR:  next_state_s = INST_FETCH;
      INST_FETCH: begin
        if (wait_done_s) next_state_s = INST_LOAD;
        else             next_state_s = INST_FETCH;
      end
      INST_LOAD:  next_state_s = IDLE;
      IDLE:       next_state_s = OP_ADDR;
      OP_ADDR: begin
        if (op_s == HLT) next_state_s = HALTED;
        else             next_state_s = OP_FETCH;
      end
      OP_FETCH: begin
        if (aluop_s && !wait_done_s) next_state_s = OP_FETCH;
        else                         next_state_s = ALU_OP;
      end
      ALU_OP:     next_state_s = STORE;
      STORE: begin
`ifdef CTRL_SEQ_SINGLE_STEP_EN
        if (step_mode) next_state_s = STEP_HOLD;
        else           next_state_s = INST_ADDR;
`else
        next_state_s = INST_ADDR;
`endif
      end
      HALTED: begin
        if (run) next_state_s = INST_ADDR;
        else     next_state_s = HALTED;
      end
`ifdef CTRL_SEQ_SINGLE_STEP_EN
      STEP_HOLD: begin
        if (step) next_state_s = INST_ADDR;
        else      next_state_s = STEP_HOLD;
      end
`endif
      default:    next_state_s = INST_ADDR;
    endcase
  end

  // Strobe decode; STEP_HOLD and illegal encodings fall to the all-zero default
  always_comb begin
    load_ac    = 1'b0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    inc_pc     = 1'b0;
    load_pc    = 1'b0;
    load_ir    = 1'b0;
    halt       = 1'b0;
    instr_done = 1'b0;
    case (state_r)
      INST_ADDR:  mem_rd = 1'b0;
      INST_FETCH: mem_rd = 1'b1;
      INST_LOAD, IDLE: begin
        mem_rd  = 1'b1;
        load_ir = 1'b1;
      end
      OP_ADDR: begin
        inc_pc = 1'b1;
        halt   = (op_s == HLT);
      end
      OP_FETCH:   mem_rd = aluop_s;
      ALU_OP: begin
        mem_rd  = aluop_s;
        load_ac = aluop_s;
        inc_pc  = (op_s == SKZ) && zero;
        load_pc = (op_s == JMP);
      end
      STORE: begin
        mem_rd     = aluop_s;
        load_ac    = aluop_s;
        load_pc    = (op_s == JMP);
        inc_pc     = (op_s == JMP);
        mem_wr     = (op_s == STO);
        instr_done = 1'b1;
      end
      HALTED:     halt = 1'b1;
      default:    halt = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_ctrl_seq.sv
// Randomised self-checking bench for ctrl_seq: two instances (MEM_WAIT 0 and 2)
// compared cycle by cycle against per-instruction expected traces.
module tb_ctrl_seq;
  import ctrl_seq_pkg::*;

  logic        clk;
  logic        rst_;
  logic [2:0]  opc    [2];
  logic        zero_v [2];
  logic        run_v  [2];
  logic [11:0] obs    [2];
  logic [11:0] exp_q  [$];
  int          n_vec;
  int          n_err;

  logic        la0, rd0, wr0, ip0, lp0, li0, h0, dn0;
  logic        la1, rd1, wr1, ip1, lp1, li1, h1, dn1;
  ctrl_state_t st0, st1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ctrl_seq #(.MEM_WAIT(0), .OPCODE_W(3)) u_dut0 (
    .clk(clk), .rst_(rst_), .opcode(opc[0]), .zero(zero_v[0]), .run(run_v[0]),
    .load_ac(la0), .mem_rd(rd0), .mem_wr(wr0), .inc_pc(ip0), .load_pc(lp0),
    .load_ir(li0), .halt(h0), .instr_done(dn0), .state(st0)
`ifdef CTRL_SEQ_SINGLE_STEP_EN
    , .step_mode(1'b0), .step(1'b0)
`endif
  );

  ctrl_seq #(.MEM_WAIT(2), .OPCODE_W(3)) u_dut1 (
    .clk(clk), .rst_(rst_), .opcode(opc[1]), .zero(zero_v[1]), .run(run_v[1]),
    .load_ac(la1), .mem_rd(rd1), .mem_wr(wr1), .inc_pc(ip1), .load_pc(lp1),
    .load_ir(li1), .halt(h1), .instr_done(dn1), .state(st1)
`ifdef CTRL_SEQ_SINGLE_STEP_EN
    , .step_mode(1'b0), .step(1'b0)
`endif
  );

  assign obs[0] = {st0, la0, rd0, wr0, ip0, lp0, li0, h0, dn0};
  assign obs[1] = {st1, la1, rd1, wr1, ip1, lp1, li1, h1, dn1};

  task automatic check_eq(input string tag, input logic [11:0] got, input logic [11:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // {state, load_ac, mem_rd, mem_wr, inc_pc, load_pc, load_ir, halt, instr_done}
  function automatic logic [11:0] mk(input logic [3:0] st, input logic la, input logic rd,
                                     input logic wr, input logic ip, input logic lp,
                                     input logic li, input logic h, input logic dn);
    return {st, la, rd, wr, ip, lp, li, h, dn};
  endfunction

  // Expected per-cycle trace of one instruction, from INST_ADDR up to OP_ADDR (HLT) or STORE
  task automatic build(input logic [2:0] op, input logic z, input int mw);
    logic alu;
    alu = (op >= 3'd2) && (op <= 3'd5);
    exp_q.delete();
    exp_q.push_back(mk(4'd0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i <= mw; i++) exp_q.push_back(mk(4'd1, 0, 1, 0, 0, 0, 0, 0, 0));
    exp_q.push_back(mk(4'd2, 0, 1, 0, 0, 0, 1, 0, 0));
    exp_q.push_back(mk(4'd3, 0, 1, 0, 0, 0, 1, 0, 0));
    exp_q.push_back(mk(4'd4, 0, 0, 0, 1, 0, 0, op == 3'd0, 0));
    if (op != 3'd0) begin
      for (int i = 0; i < (alu ? mw + 1 : 1); i++)
        exp_q.push_back(mk(4'd5, 0, alu, 0, 0, 0, 0, 0, 0));
      exp_q.push_back(mk(4'd6, alu, alu, 0, (op == 3'd1) && z, op == 3'd7, 0, 0, 0));
      exp_q.push_back(mk(4'd7, alu, alu, op == 3'd6, op == 3'd7, op == 3'd7, 0, 0, 1));
    end
  endtask

  task automatic do_reset(input int d);
    rst_ = 1'b1;
    #1;
    check_eq($sformatf("d%0d reset_async", d), obs[d], 12'h000);
    @(negedge clk);
    check_eq($sformatf("d%0d reset_held", d), obs[d], 12'h000);
    rst_ = 1'b0;
  endtask

  // Runs one instruction on instance d; abort asserts reset in the middle of STORE
  task automatic run_instr(input int d, input logic [2:0] op, input logic z,
                           input int halt_cycles, input bit abort);
    build(op, z, (d == 0) ? 0 : 2);
    zero_v[d] = z;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (exp_q[i][11:8] <= 4'd1) opc[d] = 3'($urandom_range(0, 7));
      else                        opc[d] = op;
      run_v[d] = 1'($urandom_range(0, 1));
      #1;
      check_eq($sformatf("d%0d op%0d z%0d cyc%0d", d, op, z, i), obs[d], exp_q[i]);
      if (abort && (exp_q[i][11:8] == 4'd7)) begin
        #1 rst_ = 1'b1;
        #1;
        check_eq($sformatf("d%0d store_abort_async", d), obs[d], 12'h000);
        @(negedge clk);
        check_eq($sformatf("d%0d store_abort_held", d), obs[d], 12'h000);
        rst_ = 1'b0;
        break;
      end
      @(negedge clk);
    end
    if (op == 3'd0) begin
      run_v[d] = 1'b0;
      for (int i = 0; i < halt_cycles; i++) begin
        #1;
        check_eq($sformatf("d%0d halted%0d", d, i), obs[d], mk(4'd8, 0, 0, 0, 0, 0, 0, 1, 0));
        @(negedge clk);
      end
      run_v[d] = 1'b1;
      #1;
      check_eq($sformatf("d%0d halted_run", d), obs[d], mk(4'd8, 0, 0, 0, 0, 0, 0, 1, 0));
      @(negedge clk);
      run_v[d] = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_  = 1'b1;
    for (int d = 0; d < 2; d++) begin
      opc[d]    = 3'd0;
      zero_v[d] = 1'b0;
      run_v[d]  = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      do_reset(d);
      run_instr(d, 3'd2, 1'b0, 0, 1'b0);  // ADD
      run_instr(d, 3'd5, 1'b1, 0, 1'b0);  // LDA
      run_instr(d, 3'd7, 1'b0, 0, 1'b0);  // JMP
      run_instr(d, 3'd1, 1'b1, 0, 1'b0);  // SKZ taken
      run_instr(d, 3'd1, 1'b0, 0, 1'b0);  // SKZ not taken
      run_instr(d, 3'd0, 1'b0, 20, 1'b0); // HLT
      run_instr(d, 3'd6, 1'b0, 0, 1'b0);  // STO
      run_instr(d, 3'd6, 1'b0, 0, 1'b1);  // STO aborted by reset
      run_instr(d, 3'd4, 1'b1, 0, 1'b0);  // XOR straight after reset
      for (int k = 0; k < 30; k++)
        run_instr(d, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  int'($urandom_range(0, 5)), 1'b0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ctrl_seq.md
Name: ctrl_seq

Overview:
- Parametrised successor to the VeriRISC 8-state control sequencer; drives the memory, PC, IR and accumulator control strobes from the current opcode and the zero flag.
- Adds programmable memory wait states, a sticky HALTED state with a run/resume input, an instruction-complete pulse and a debug state output.
- Sits between the instruction register / ALU flags and the datapath load/enable strobes inside the CPU top level.

Parameters:
- MEM_WAIT, 0: extra cycles each memory-read state (INST_FETCH, and OP_FETCH for ALU-class ops) is held; range 0..15.
- OPCODE_W, 3: opcode width; must match opcode_t in the package.

Ports:
- clk, input, 1: clock; all state updates on rising edge.
- rst_, input, 1: reset, asynchronous, active-high (asserted when 1).
- opcode, input, OPCODE_W (opcode_t): current IR opcode.
- zero, input, 1: accumulator-zero flag.
- run, input, 1: resume request; sampled only in HALTED.
- load_ac, mem_rd, mem_wr, inc_pc, load_pc, load_ir, output, 1 each: datapath strobes.
- halt, output, 1: high in OP_ADDR when opcode==HLT, and throughout HALTED.
- instr_done, output, 1: one-cycle pulse in the final cycle of STORE.
- state, output, 4 (ctrl_state_t): current state, for debug.

Behaviour:
- Reset: state=INST_ADDR, wait_cnt=0; all strobes, halt and instr_done are 0 while rst_=1. rst_ asserted mid-instruction aborts immediately; there is no partial write-back.
- ALUOP = opcode in {ADD,AND,XOR,LDA}. Strobes are decoded combinationally from state/opcode/zero; any strobe not listed for a state is 0.
- INST_ADDR: no strobes -> INST_FETCH.
- INST_FETCH: mem_rd. Held while wait_cnt!=MEM_WAIT (wait_cnt increments each held cycle), then -> INST_LOAD with wait_cnt cleared.
- INST_LOAD: mem_rd, load_ir -> IDLE.
- IDLE: mem_rd, load_ir -> OP_ADDR.
- OP_ADDR: inc_pc; halt=(opcode==HLT). HLT -> HALTED, else -> OP_FETCH.
- OP_FETCH: mem_rd=ALUOP. If ALUOP, wait-state hold as in INST_FETCH; non-ALU ops never wait. -> ALU_OP.
- ALU_OP: mem_rd=load_ac=ALUOP; inc_pc=(SKZ && zero); load_pc=(JMP) -> STORE.
- STORE: mem_rd=load_ac=ALUOP; load_pc=inc_pc=(JMP); mem_wr=(STO); instr_done=1 -> INST_ADDR.
- HALTED: halt=1, other strobes 0. Stays until run=1, then -> INST_ADDR. The PC was already incremented in OP_ADDR, so execution resumes at the next instruction.
- Timing: non-ALU instruction = 8+MEM_WAIT cycles; ALU instruction = 8+2*MEM_WAIT cycles; HLT = 5+MEM_WAIT cycles to reach HALTED.
- wait_cnt width = max(1,$clog2(MEM_WAIT+1)); it never wraps and clears on every state exit.
- Illegal state encodings -> INST_ADDR next cycle, with all strobes 0.
- Opcode changes during wait cycles are tolerated; decode always uses the current opcode.

Optional Feature:
- Macro CTRL_SEQ_SINGLE_STEP_EN.
- Defined: adds inputs step_mode and step (1 bit each). When step_mode=1, STORE goes to STEP_HOLD instead of INST_ADDR. In STEP_HOLD all outputs are 0; it exits to INST_ADDR on step=1. step_mode=0 gives normal flow. A step held high advances one instruction per STEP_HOLD visit.
- Undefined: ports absent; the STEP_HOLD encoding is reserved and unreachable, and is treated as illegal.

Decomposition:
- Package typedefs: opcode_t (HLT=0,SKZ=1,ADD=2,AND=3,XOR=4,LDA=5,STO=6,JMP=7) and ctrl_state_t (4-bit: INST_ADDR=0..STORE=7, HALTED=8, STEP_HOLD=9). Also holds the ALUOP opcode set as a package function is_aluop().
- Sub-module ctrl_wait_cnt: the wait-state counter, with inputs hold_req and clear and output done. Everything else stays in ctrl_seq.

Test Plan:
- MEM_WAIT=0, opcode=ADD -> state sequence 0,1,2,3,4,5,6,7,0; load_ac high in states 6 and 7; instr_done pulses once in 8 cycles.
- MEM_WAIT=2, opcode=LDA -> INST_FETCH held 3 cycles and OP_FETCH held 3 cycles; total 12 cycles; mem_rd high throughout both holds.
- MEM_WAIT=2, opcode=JMP -> OP_FETCH not held; 10 cycles; load_pc in ALU_OP and STORE; inc_pc in STORE.
- opcode=SKZ with zero=1 -> inc_pc in OP_ADDR and ALU_OP. With zero=0 -> inc_pc in OP_ADDR only.
- opcode=HLT -> halt in OP_ADDR, then HALTED held with run=0 for 20 cycles; run=1 -> INST_ADDR next cycle.
- rst_=1 asserted asynchronously in STORE with opcode=STO -> mem_wr drops without waiting for a clock edge; state=INST_ADDR. With SINGLE_STEP_EN, step_mode=1: STORE -> STEP_HOLD, held until the step pulse.
